// File: rtl/motion_ramp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motion_ramp_scheduler: one-LSB-per-period amp/freq ramp with ESTOP         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module motion_ramp_scheduler #(
  parameter int STEP_TICKS = 4,
  parameter int W          = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         slow,
  input  logic [W-1:0] tgt_amp,
  input  logic [W-1:0] tgt_freq,
  input  logic         tgt_valid,
  input  logic         error_in,
  input  logic         cycle_end,
  output logic [W-1:0] out_amp,
  output logic [W-1:0] out_freq,
  output logic         at_target,
  output logic         busy,
  output logic         stop_done
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_ESTOP = 1'b1;
  localparam logic [7:0] c_step_ticks = 8'(STEP_TICKS);

  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic [W-1:0] r_tgt_amp;
  logic [W-1:0] r_tgt_freq;
  logic [7:0]   r_cnt;
  logic         r_pending;

  logic         w_on_target;
  logic         w_step_en;
  logic         w_exit;
  logic [7:0]   w_cnt_inc;

  assign w_on_target = (out_amp == r_tgt_amp) && (out_freq == r_tgt_freq);
  assign w_step_en   = (r_state == ST_RUN) && !error_in && r_pending && cycle_end && !w_on_target;
  assign w_exit      = (r_state == ST_ESTOP) && !error_in && tgt_valid;
  assign w_cnt_inc   = r_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (error_in) w_state_nxt = ST_ESTOP;
      ST_ESTOP: if (w_exit)   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    at_target = (r_state == ST_RUN) && w_on_target;
    busy      = !at_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_amp    <= '0;
      out_freq   <= '0;
      r_tgt_amp  <= '0;
      r_tgt_freq <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      stop_done  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (error_in) begin
        r_cnt     <= '0;
        r_pending <= 1'b0;
      end else begin
        if (tgt_valid) begin
          r_tgt_amp  <= tgt_amp;
          r_tgt_freq <= tgt_freq;
        end
        // Each step moves strictly toward the old target, so it can never wrap.
        if (w_step_en) begin
          r_pending <= 1'b0;
          if (out_amp > r_tgt_amp)
            out_amp <= out_amp - 1'b1;
          else if (out_freq > r_tgt_freq)
            out_freq <= out_freq - 1'b1;
          else if (out_freq < r_tgt_freq)
            out_freq <= out_freq + 1'b1;
          else
            out_amp <= out_amp + 1'b1;
        end else if (!r_pending && slow) begin
          if (w_cnt_inc == c_step_ticks) begin
            r_pending <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      end
    end else begin
      if (w_exit) begin
        r_tgt_amp  <= tgt_amp;
        r_tgt_freq <= tgt_freq;
        stop_done  <= 1'b0;
        r_cnt      <= '0;
        r_pending  <= 1'b0;
      end else if (cycle_end) begin
        if (out_amp != '0) begin
          out_amp <= out_amp - 1'b1;
        end else begin
          out_freq  <= '0;
          stop_done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motion_ramp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_motion_ramp_scheduler: vector table + scoreboard bench, STEP_TICKS=2    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_motion_ramp_scheduler;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         slow;
  logic [W-1:0] tgt_amp;
  logic [W-1:0] tgt_freq;
  logic         tgt_valid;
  logic         error_in;
  logic         cycle_end;
  logic [W-1:0] out_amp;
  logic [W-1:0] out_freq;
  logic         at_target;
  logic         busy;
  logic         stop_done;

  motion_ramp_scheduler #(.STEP_TICKS(2), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .slow(slow), .tgt_amp(tgt_amp), .tgt_freq(tgt_freq),
    .tgt_valid(tgt_valid), .error_in(error_in), .cycle_end(cycle_end),
    .out_amp(out_amp), .out_freq(out_freq), .at_target(at_target),
    .busy(busy), .stop_done(stop_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s, c, v, e;
    logic [W-1:0] a, f;
    logic [W-1:0] ea, ef;
    logic         et, ed;
  } vec_t;

  typedef struct {
    logic [W-1:0] a, f;
    logic         t, d;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_idx  = 0;

  function automatic vec_t mk(input logic s, c, v, input int a, f, input logic e,
                              input int ea, ef, input logic et, ed);
    vec_t r;
    r.s = s; r.c = c; r.v = v; r.e = e;
    r.a = 3'(a); r.f = 3'(f);
    r.ea = 3'(ea); r.ef = 3'(ef); r.et = et; r.ed = ed;
    return r;
  endfunction

  task automatic check(input string name, input exp_t x);
    logic [8:0] got, want;
    got  = {out_amp, out_freq, at_target, busy, stop_done};
    want = {x.a, x.f, x.t, !x.t, x.d};
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got amp=%0d freq=%0d at=%0b busy=%0b sd=%0b, want amp=%0d freq=%0d at=%0b busy=%0b sd=%0b",
                  name, out_amp, out_freq, at_target, busy, stop_done, x.a, x.f, x.t, !x.t, x.d);
  endtask

  task automatic apply(input vec_t vv);
    exp_t x;
    @(negedge clk);
    slow = vv.s; cycle_end = vv.c; tgt_valid = vv.v; error_in = vv.e;
    tgt_amp = vv.a; tgt_freq = vv.f;
    x.a = vv.ea; x.f = vv.ef; x.t = vv.et; x.d = vv.ed;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: queue empty at vector %0d", vec_idx);
    end else begin
      check($sformatf("vec%0d", vec_idx), exp_q.pop_front());
    end
    vec_idx++;
  endtask

  // Two slows then a cycle_end: one full step landing on (a,f).
  task automatic push_step(input int a, f, input logic t);
    tbl.push_back(mk(1,0,0,0,0,0, -1,-1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, -1,-1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,  a, f, t,0));
  endtask

  // Steps are filled with placeholders for pre-step outputs; resolved below.
  task automatic fix_placeholders();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ea == 3'h7 && tbl[i].ef == 3'h7) begin
        tbl[i].ea = tbl[i-1].ea; tbl[i].ef = tbl[i-1].ef; tbl[i].et = tbl[i-1].et;
      end
    end
  endtask

  exp_t xr;

  initial begin
    rst_n = 1'b0; slow = 0; cycle_end = 0; tgt_valid = 0; error_in = 0;
    tgt_amp = '0; tgt_freq = '0;

    // Test 2
    tbl.push_back(mk(0,0,1,3,2,0, 0,0,0,0));
    push_step(0,1,0); push_step(0,2,0); push_step(1,2,0); push_step(2,2,0); push_step(3,2,1);
    // Test 3
    tbl.push_back(mk(0,0,1,1,4,0, 3,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 3,2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 3,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 3,2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 3,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 2,2,0,0));
    push_step(1,2,0); push_step(1,3,0); push_step(1,4,1);
    // Test 4: coincident cycle_end, retarget keeps counter and pending
    tbl.push_back(mk(0,0,1,2,4,0, 1,4,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,4,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 1,4,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 2,4,1,0));
    tbl.push_back(mk(0,0,1,0,4,0, 2,4,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2,4,0,0));
    tbl.push_back(mk(0,0,1,1,4,0, 2,4,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2,4,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,4,1,0));
    tbl.push_back(mk(0,0,1,0,4,0, 1,4,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,4,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,4,0,0));
    tbl.push_back(mk(0,0,1,0,3,0, 1,4,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,4,0,0));
    push_step(0,3,1);
    tbl.push_back(mk(1,0,0,0,0,0, 0,3,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,3,1,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,3,1,0));
    tbl.push_back(mk(0,0,1,1,3,0, 0,3,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,3,1,0));
    tbl.push_back(mk(0,0,1,3,2,0, 1,3,0,0));
    push_step(1,2,0); push_step(2,2,0); push_step(3,2,1);
    // Test 5: emergency wind-down and exit
    tbl.push_back(mk(1,0,0,0,0,1, 3,2,0,0));
    tbl.push_back(mk(1,1,0,0,0,1, 2,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 1,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,0,1));
    tbl.push_back(mk(0,0,1,1,1,1, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,1,1,1,0, 0,0,0,0));
    push_step(0,1,0); push_step(1,1,1);
    // Test 6: error on a step-eligible cycle_end
    tbl.push_back(mk(0,0,1,2,1,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,1,0));
    fix_placeholders();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    xr.a = 0; xr.f = 0; xr.t = 1; xr.d = 0;
    check("reset_state", xr);

    // Test 1: ramp toward 3/1, then asynchronous reset at 2/1
    @(negedge clk); rst_n = 1'b1;
    apply(mk(0,0,1,3,1,0, 0,0,0,0));
    apply(mk(1,0,0,0,0,0, 0,0,0,0)); apply(mk(1,0,0,0,0,0, 0,0,0,0)); apply(mk(0,1,0,0,0,0, 0,1,0,0));
    apply(mk(1,0,0,0,0,0, 0,1,0,0)); apply(mk(1,0,0,0,0,0, 0,1,0,0)); apply(mk(0,1,0,0,0,0, 1,1,0,0));
    apply(mk(1,0,0,0,0,0, 1,1,0,0)); apply(mk(1,0,0,0,0,0, 1,1,0,0)); apply(mk(0,1,0,0,0,0, 2,1,0,0));
    @(negedge clk);
    slow = 0; cycle_end = 0; tgt_valid = 0; error_in = 0;
    #2 rst_n = 1'b0;
    #1;
    xr.a = 0; xr.f = 0; xr.t = 1; xr.d = 0;
    check("async_reset", xr);
    @(posedge clk); #1;
    check("reset_held", xr);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
